// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: FSM encoding,
// the zero-register specifier and the active-low stall levels.
package pipe_ctrl_pkg;

    // Branch-resolution FSM encoding (exposed on ctrl_state for debug).
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1
    } ctrl_state_t;

    // Register $0 is hardwired; a load targeting it never creates a hazard.
    localparam int REG_ZERO = 0;

    // Stall outputs are active-low: STALL holds the register, GO lets it advance.
    localparam logic STALL = 1'b0;
    localparam logic GO    = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count up on inc, stick at all-ones, return to zero on clr or reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: PC stall/redirect controls, IF/ID flush and
// ID/EX bubble strobes, a branch-resolution wait FSM and stall-cycle counters.
// All controls are combinational from inputs and the registered state, so the
// consuming registers act on them at the same rising edge.
module hazard_stall_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             id_branch,
    input  logic             id_jump,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             ex_br_resolved,
    input  logic             ex_br_taken,
    input  logic             dmem_ready,
    input  logic             cnt_clr,
    output logic             datastall,
    output logic             controlstall,
    output logic             branch_enable,
    output logic             jump_enable,
    output logic             flush_ifid,
    output logic             bubble_idex,
    output logic             freeze,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] data_stall_cnt,
    output logic [CNT_W-1:0] ctrl_stall_cnt
);

    ctrl_state_t state;
    ctrl_state_t state_next;
    logic        lu;
    logic        data_inc;
    logic        ctrl_inc;

    // Load-use hazard: the load in EX writes a register the ID instruction reads.
    assign lu = ex_memread && (ex_rt != REG_W'(REG_ZERO)) &&
                ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));

    // State register; reset abandons any pending branch wait.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Priority-ordered control decode: freeze, branch wait, load-use, jump, branch.
    always_comb begin
        datastall     = GO;
        controlstall  = GO;
        branch_enable = 1'b0;
        jump_enable   = 1'b0;
        flush_ifid    = 1'b0;
        bubble_idex   = 1'b0;
        freeze        = 1'b0;
        state_next    = state;
        if (reset) begin
            state_next = RUN;
        end else if (!dmem_ready) begin
            // EX is frozen too, so a resolved outcome is still there next cycle.
            freeze       = 1'b1;
            datastall    = STALL;
            controlstall = STALL;
        end else if (state == BR_WAIT) begin
            if (ex_br_resolved) begin
                state_next = RUN;
                if (ex_br_taken) begin
                    branch_enable = 1'b1;
                    flush_ifid    = 1'b1;
                end
            end else begin
                controlstall = STALL;
                flush_ifid   = 1'b1;
            end
        end else if (lu) begin
            // Branch/jump on the stalled instruction is handled once it re-issues.
            datastall   = STALL;
            bubble_idex = 1'b1;
        end else if (id_jump) begin
            // Jump wins over an (illegal) simultaneous branch.
            jump_enable = 1'b1;
            flush_ifid  = 1'b1;
        end else if (id_branch) begin
            controlstall = STALL;
            flush_ifid   = 1'b1;
            state_next   = BR_WAIT;
        end
    end

    assign ctrl_state = state;
    assign data_inc   = (datastall == STALL);
    assign ctrl_inc   = (controlstall == STALL) && !freeze;

    sat_counter #(.W(CNT_W)) u_data_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (data_inc),
        .count (data_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_ctrl_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (ctrl_inc),
        .count (ctrl_stall_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: directed scenarios plus a random
// run, all compared against a rule-level reference model.
module tb_hazard_stall_ctrl;

    localparam int REG_W   = 5;
    localparam int CNT_W   = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] id_rs, id_rt, ex_rt;
    logic             id_uses_rs, id_uses_rt, id_branch, id_jump, ex_memread;
    logic             ex_br_resolved, ex_br_taken, dmem_ready, cnt_clr;
    logic             datastall, controlstall, branch_enable, jump_enable;
    logic             flush_ifid, bubble_idex, freeze;
    logic [1:0]       ctrl_state;
    logic [CNT_W-1:0] data_stall_cnt, ctrl_stall_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_br_wait;
    int m_dcnt;
    int m_ccnt;

    logic [6:0] act_vec;
    assign act_vec = {datastall, controlstall, branch_enable, jump_enable,
                      flush_ifid, bubble_idex, freeze};

    // clock
    always #5 clk = ~clk;

    hazard_stall_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rs     (id_uses_rs),
        .id_uses_rt     (id_uses_rt),
        .id_branch      (id_branch),
        .id_jump        (id_jump),
        .ex_memread     (ex_memread),
        .ex_rt          (ex_rt),
        .ex_br_resolved (ex_br_resolved),
        .ex_br_taken    (ex_br_taken),
        .dmem_ready     (dmem_ready),
        .cnt_clr        (cnt_clr),
        .datastall      (datastall),
        .controlstall   (controlstall),
        .branch_enable  (branch_enable),
        .jump_enable    (jump_enable),
        .flush_ifid     (flush_ifid),
        .bubble_idex    (bubble_idex),
        .freeze         (freeze),
        .ctrl_state     (ctrl_state),
        .data_stall_cnt (data_stall_cnt),
        .ctrl_stall_cnt (ctrl_stall_cnt)
    );

    // ---------------- reference model ----------------
    function automatic bit model_lu();
        return ex_memread && (ex_rt != 0) &&
               ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
    endfunction

    // {datastall, controlstall, branch_en, jump_en, flush, bubble, freeze}
    function automatic logic [6:0] model_ctrl();
        if (reset)       return 7'b1100000;
        if (!dmem_ready) return 7'b0000001;
        if (m_br_wait)   return ex_br_resolved ? (ex_br_taken ? 7'b1110100 : 7'b1100000)
                                               : 7'b1000100;
        if (model_lu())  return 7'b0100010;
        if (id_jump)     return 7'b1101100;
        if (id_branch)   return 7'b1000100;
        return 7'b1100000;
    endfunction

    task automatic model_clear();
        m_br_wait = 1'b0;
        m_dcnt    = 0;
        m_ccnt    = 0;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_advance();
        logic [6:0] e;
        e = model_ctrl();
        if (reset) begin
            model_clear();
            return;
        end
        if (cnt_clr) begin
            m_dcnt = 0;
            m_ccnt = 0;
        end else begin
            if (!e[6] && m_dcnt < CNT_MAX) m_dcnt++;
            if (!e[5] && !e[0] && m_ccnt < CNT_MAX) m_ccnt++;
        end
        // Unfrozen: a wait ends on resolution; in RUN only a branch stalls control.
        if (!e[0]) m_br_wait = m_br_wait ? !ex_br_resolved : !e[5];
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        id_rs = '0; id_rt = '0; ex_rt = '0;
        id_uses_rs = 0; id_uses_rt = 0; id_branch = 0; id_jump = 0;
        ex_memread = 0; ex_br_resolved = 0; ex_br_taken = 0;
        dmem_ready = 1; cnt_clr = 0;
    endtask

    task automatic tick();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        set_idle();
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1;
        set_idle();
        dmem_ready = 0;
        id_branch  = 1;
        model_clear();
        #2;
        checks++; if (act_vec !== 7'b1100000) begin errors++;
            $display("FAIL reset_outputs got %b want %b", act_vec, 7'b1100000); end
        checks++; if (ctrl_state !== 2'd0) begin errors++;
            $display("FAIL reset_state got %0d want 0", ctrl_state); end
        checks++; if (data_stall_cnt !== '0 || ctrl_stall_cnt !== '0) begin errors++;
            $display("FAIL reset_counters got %0d/%0d want 0/0", data_stall_cnt, ctrl_stall_cnt); end
        @(posedge clk);
        #1;
        reset = 0;
        set_idle();
    endtask

    task automatic test_load_use();
        clear_counters();
        ex_memread = 1; ex_rt = 5'd8; id_rs = 5'd8; id_uses_rs = 1;
        #3;
        checks++; if (datastall !== 1'b0 || bubble_idex !== 1'b1) begin errors++;
            $display("FAIL lu_stall got ds=%b bub=%b want ds=0 bub=1", datastall, bubble_idex); end
        checks++; if (act_vec !== model_ctrl()) begin errors++;
            $display("FAIL lu_vec got %b want %b", act_vec, model_ctrl()); end
        tick();
        set_idle();
        #3;
        checks++; if (datastall !== 1'b1 || bubble_idex !== 1'b0) begin errors++;
            $display("FAIL lu_release got ds=%b bub=%b want ds=1 bub=0", datastall, bubble_idex); end
        checks++; if (data_stall_cnt !== 16'd1) begin errors++;
            $display("FAIL lu_count got %0d want 1", data_stall_cnt); end
        tick();
        ex_memread = 1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1;
        #3;
        checks++; if (datastall !== 1'b1 || bubble_idex !== 1'b0) begin errors++;
            $display("FAIL lu_zero_reg got ds=%b bub=%b want ds=1 bub=0", datastall, bubble_idex); end
        tick();
        set_idle();
    endtask

    task automatic test_branch(input bit taken);
        clear_counters();
        id_branch = 1;
        #3;
        checks++; if (controlstall !== 1'b0 || flush_ifid !== 1'b1) begin errors++;
            $display("FAIL br%0d_detect got cs=%b fl=%b want cs=0 fl=1", taken, controlstall, flush_ifid); end
        tick();
        set_idle();
        #3;
        checks++; if (controlstall !== 1'b0 || flush_ifid !== 1'b1 || ctrl_state !== 2'd1) begin errors++;
            $display("FAIL br%0d_wait got cs=%b fl=%b st=%0d want cs=0 fl=1 st=1",
                     taken, controlstall, flush_ifid, ctrl_state); end
        tick();
        ex_br_resolved = 1; ex_br_taken = taken;
        #3;
        checks++; if (act_vec !== (taken ? 7'b1110100 : 7'b1100000)) begin errors++;
            $display("FAIL br%0d_resolve got %b want %b", taken, act_vec,
                     taken ? 7'b1110100 : 7'b1100000); end
        tick();
        set_idle();
        #3;
        checks++; if (ctrl_state !== 2'd0 || branch_enable !== 1'b0) begin errors++;
            $display("FAIL br%0d_after got st=%0d be=%b want st=0 be=0", taken, ctrl_state, branch_enable); end
        checks++; if (ctrl_stall_cnt !== 16'd2) begin errors++;
            $display("FAIL br%0d_count got %0d want 2", taken, ctrl_stall_cnt); end
        tick();
    endtask

    task automatic test_freeze_br_wait();
        clear_counters();
        id_branch = 1;
        tick();
        set_idle();
        ex_br_resolved = 1; ex_br_taken = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #3;
            checks++; if (branch_enable !== 1'b0 || ctrl_state !== 2'd1 || freeze !== 1'b1) begin errors++;
                $display("FAIL frz_hold%0d got be=%b st=%0d fr=%b want be=0 st=1 fr=1",
                         i, branch_enable, ctrl_state, freeze); end
            tick();
        end
        dmem_ready = 1;
        #3;
        checks++; if (branch_enable !== 1'b1 || flush_ifid !== 1'b1) begin errors++;
            $display("FAIL frz_release got be=%b fl=%b want be=1 fl=1", branch_enable, flush_ifid); end
        checks++; if (data_stall_cnt !== 16'd3) begin errors++;
            $display("FAIL frz_dcount got %0d want 3", data_stall_cnt); end
        tick();
        set_idle();
        #3;
        checks++; if (ctrl_state !== 2'd0) begin errors++;
            $display("FAIL frz_state got %0d want 0", ctrl_state); end
        tick();
    endtask

    task automatic test_lu_and_jump();
        set_idle();
        ex_memread = 1; ex_rt = 5'd3; id_rt = 5'd3; id_uses_rt = 1; id_jump = 1;
        #3;
        checks++; if (jump_enable !== 1'b0 || datastall !== 1'b0) begin errors++;
            $display("FAIL lujmp_stall got je=%b ds=%b want je=0 ds=0", jump_enable, datastall); end
        tick();
        ex_memread = 0;
        #3;
        checks++; if (jump_enable !== 1'b1 || flush_ifid !== 1'b1 || branch_enable !== 1'b0) begin errors++;
            $display("FAIL lujmp_go got je=%b fl=%b be=%b want je=1 fl=1 be=0",
                     jump_enable, flush_ifid, branch_enable); end
        tick();
        set_idle();
    endtask

    task automatic test_async_reset();
        clear_counters();
        id_branch = 1;
        tick();
        set_idle();
        #2;
        checks++; if (ctrl_state !== 2'd1 || ctrl_stall_cnt !== 16'd1) begin errors++;
            $display("FAIL arst_pre got st=%0d cc=%0d want st=1 cc=1", ctrl_state, ctrl_stall_cnt); end
        reset = 1;
        #1;
        checks++; if (ctrl_state !== 2'd0 || act_vec !== 7'b1100000) begin errors++;
            $display("FAIL arst_now got st=%0d vec=%b want st=0 vec=1100000", ctrl_state, act_vec); end
        checks++; if (data_stall_cnt !== '0 || ctrl_stall_cnt !== '0) begin errors++;
            $display("FAIL arst_cnt got %0d/%0d want 0/0", data_stall_cnt, ctrl_stall_cnt); end
        model_clear();
        @(posedge clk);
        #1;
        reset = 0;
    endtask

    task automatic test_saturation();
        clear_counters();
        dmem_ready = 0;
        for (int i = 0; i < CNT_MAX + 5; i++) tick();
        #3;
        checks++; if (data_stall_cnt !== 16'hFFFF) begin errors++;
            $display("FAIL sat_reach got %h want ffff", data_stall_cnt); end
        tick();
        #3;
        checks++; if (data_stall_cnt !== 16'hFFFF || ctrl_stall_cnt !== 16'd0) begin errors++;
            $display("FAIL sat_hold got %h/%h want ffff/0000", data_stall_cnt, ctrl_stall_cnt); end
        cnt_clr = 1;
        tick();
        cnt_clr = 0;
        #3;
        checks++; if (data_stall_cnt !== 16'd0) begin errors++;
            $display("FAIL sat_clear got %h want 0000", data_stall_cnt); end
        tick();
        set_idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            id_rs          = 5'($urandom_range(0, 3));
            id_rt          = 5'($urandom_range(0, 3));
            ex_rt          = 5'($urandom_range(0, 3));
            id_uses_rs     = 1'($urandom_range(0, 1));
            id_uses_rt     = 1'($urandom_range(0, 1));
            ex_memread     = ($urandom_range(0, 2) == 0);
            id_jump        = ($urandom_range(0, 5) == 0);
            id_branch      = ($urandom_range(0, 3) == 0);
            ex_br_resolved = ($urandom_range(0, 2) == 0);
            ex_br_taken    = 1'($urandom_range(0, 1));
            dmem_ready     = ($urandom_range(0, 5) != 0);
            cnt_clr        = ($urandom_range(0, 30) == 0);
            #3;
            checks++; if (act_vec !== model_ctrl()) begin errors++;
                $display("FAIL rnd_vec cycle %0d got %b want %b", i, act_vec, model_ctrl()); end
            checks++; if (ctrl_state !== {1'b0, m_br_wait}) begin errors++;
                $display("FAIL rnd_state cycle %0d got %0d want %0d", i, ctrl_state, m_br_wait); end
            checks++; if (data_stall_cnt !== CNT_W'(m_dcnt) || ctrl_stall_cnt !== CNT_W'(m_ccnt)) begin errors++;
                $display("FAIL rnd_cnt cycle %0d got %0d/%0d want %0d/%0d",
                         i, data_stall_cnt, ctrl_stall_cnt, m_dcnt, m_ccnt); end
            tick();
        end
        set_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_load_use();
        test_branch(1'b1);
        test_branch(1'b0);
        test_freeze_br_wait();
        test_lu_and_jump();
        test_async_reset();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline sequencing controller for the 5-stage MIPS core. It generates the PC register's stall and redirect controls: `datastall`, `controlstall`, `branch_enable` and `jump_enable`. It also generates the IF/ID and ID/EX flush/bubble strobes, from ID-stage operand usage, EX-stage load/branch status and data-memory readiness. It keeps a small FSM for branch-resolution waits and saturating stall-cycle performance counters.

## Interface
- `REG_W`, 5, register-specifier width
- `CNT_W`, 16, performance counter width
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-high
- `id_rs`, `id_rt` in REG_W: source specifiers of the instruction in ID
- `id_uses_rs`, `id_uses_rt` in 1: ID instruction actually reads rs/rt
- `id_branch` in 1: ID holds a conditional branch
- `id_jump` in 1: ID holds a jump (target available in ID)
- `ex_memread` in 1: EX holds a load
- `ex_rt` in REG_W: load destination in EX
- `ex_br_resolved` in 1: EX holds the branch and its outcome is valid
- `ex_br_taken` in 1: outcome, qualified by `ex_br_resolved`
- `dmem_ready` in 1: 0 = MEM stage busy, whole pipe must freeze
- `cnt_clr` in 1: synchronous clear of both counters
- `datastall` out 1: active-low, 1 = proceed, 0 = hold PC and IF/ID
- `controlstall` out 1: active-low, 1 = proceed, 0 = hold PC
- `branch_enable` out 1: load PC with the branch target
- `jump_enable` out 1: load PC with the jump target
- `flush_ifid` out 1: load IF/ID with NOP
- `bubble_idex` out 1: load ID/EX with NOP
- `freeze` out 1: hold all pipeline registers (`~dmem_ready`)
- `ctrl_state` out 2: FSM state, for debug
- `data_stall_cnt`, `ctrl_stall_cnt` out CNT_W: stall-cycle counters

## Operation
- **Reset state.** State is RUN and both counters are 0.
- **Outputs during reset.** While reset is high, `datastall` = `controlstall` = 1 and every other control output is 0.
- **FSM states:**
  - RUN = 0
  - BR_WAIT = 1
- **Load-use hazard (`lu`).** `lu` = `ex_memread` & (`ex_rt` != 0) & ((`id_uses_rs` & `id_rs` == `ex_rt`) | (`id_uses_rt` & `id_rt` == `ex_rt`)).
- **Priority, highest first, evaluated every cycle:**
  1. **Freeze.** Applies when `dmem_ready` = 0.
     - Outputs: `freeze` = 1, `datastall` = 0, `controlstall` = 0.
     - `branch_enable`, `jump_enable`, `flush_ifid` and `bubble_idex` are 0.
     - State holds; `ex_br_resolved` is ignored, because EX is frozen and the input persists.
  2. **BR_WAIT with `ex_br_resolved`.**
     - Taken: `branch_enable` = 1 and `flush_ifid` = 1.
     - Not taken: `controlstall` = 1 and no flush, so the fall-through instruction enters ID.
     - Next state is RUN.
  3. **BR_WAIT without resolution.** `controlstall` = 0 and `flush_ifid` = 1. State holds.
  4. **RUN with `lu`.** `datastall` = 0 and `bubble_idex` = 1, for exactly one cycle per hazard. Branch/jump detection on the stalled instruction is deferred to the next cycle.
  5. **RUN with `id_jump`.** `jump_enable` = 1 and `flush_ifid` = 1, for one cycle.
  6. **RUN with `id_branch`.** `controlstall` = 0 and `flush_ifid` = 1. Next state is BR_WAIT.
  7. **Otherwise.** All strobes are 0 and both stalls are 1.
- **Jump/branch conflict.** `id_jump` & `id_branch` together is illegal; jump wins.
- **Enable pulses.** `branch_enable` and `jump_enable` are never asserted in the same cycle. Neither is ever asserted while `datastall` = 0 or while frozen.
- **`data_stall_cnt`.** Increments on every cycle with `datastall` = 0 (load-use and freeze).
- **`ctrl_stall_cnt`.** Increments on every cycle with `controlstall` = 0 that is not frozen.
- **Counter rules:**
  - Both counters saturate at 2^CNT_W−1.
  - `cnt_clr` wins over an increment in the same cycle.

## Timing
- All control outputs are combinational from the inputs and the registered state, giving zero-cycle response.
- The consuming registers sample the controls on the same rising edge.
- State and counters update on the rising edge.
- Asserting reset asynchronously forces the outputs inactive and the state to RUN. A pending BR_WAIT is abandoned.
- **Branch cost:**
  - Taken: 1 detect cycle + N wait cycles + 1 redirect cycle.
  - Not taken: the same detect and wait cycles, with no redirect penalty after resolution.
- **Load-use penalty.** Exactly 1 cycle per hazard, extended by any freeze cycles.

## Structure
- **Shared package `pipe_ctrl_pkg`:**
  - FSM state encoding (RUN, BR_WAIT).
  - A `REG_ZERO` constant.
  - The active-low stall convention, documented as named constants `STALL = 1'b0` and `GO = 1'b1`.
- **Sub-module `sat_counter`.** Parameterised width, with clear and increment inputs. It is instantiated twice. The hazard compare stays inline.

## Test plan
- **Load-use.** `ex_memread` = 1, `ex_rt` = 8, `id_rs` = 8, `id_uses_rs` = 1, for one cycle.
  - Required: `datastall` = 0 and `bubble_idex` = 1 for that cycle only; `data_stall_cnt` = 1.
  - With `ex_rt` = 0: no stall.
- **Taken branch.** `id_branch` pulse, then 1 idle cycle, then `ex_br_resolved` = 1 with `ex_br_taken` = 1.
  - Required: `controlstall` = 0 for 2 cycles, `flush_ifid` = 1 for 3 cycles, `branch_enable` = 1 in cycle 3, `ctrl_stall_cnt` = 2.
- **Not-taken branch.** Same sequence with `ex_br_taken` = 0.
  - Required: in the resolve cycle `controlstall` = 1, `flush_ifid` = 0, `branch_enable` = 0; state returns to RUN.
- **Freeze during BR_WAIT.** `dmem_ready` = 0 for 3 cycles while `ex_br_resolved` = 1.
  - Required: no `branch_enable`, `ctrl_state` = 1 held, `data_stall_cnt` += 3.
  - After release: `branch_enable` = 1 in the next cycle.
- **Simultaneous `lu` and `id_jump`.** Required: `jump_enable` = 0 in the stall cycle and `jump_enable` = 1 in the following cycle.
- **Async reset in BR_WAIT.** Required: immediate `ctrl_state` = 0, outputs inactive, counters 0.
- **Counter saturation.** Preload to 0xFFFF via long freeze. Required: stays 0xFFFF; `cnt_clr` returns it to 0.
